// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline constants and the IF/ID record seen by the decode stage.
package mips32_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter with its next-PC selection: reset, redirect, stall hold, or word increment.
module if_fetch_unit_pc_reg
    import mips32_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;

    // Redirect wins over stall so a taken branch is never lost while decode is held.
    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect_valid) begin
            w_pc_next = i_redirect_pc;
        end else if (!i_stall) begin
            w_pc_next = r_pc + ADDR_W'(WORD_BYTES);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS32 instruction-fetch stage: drives the instruction memory and fills the IF/ID register.
module if_fetch_unit
    import mips32_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_WIDTH,
    parameter int unsigned       DATA_W   = DATA_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              if_id_valid,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc_plus4,
    output logic              misalign_err,
    output logic [31:0]       fetch_count
);

    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_redirect_pc;

    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_plus4;
    logic              r_misalign;
    logic [31:0]       r_count;

    assign w_redirect_pc = {redirect_target[ADDR_W-1:2], 2'b00};

    if_fetch_unit_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall          (stall),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (w_redirect_pc),
        .o_pc             (w_pc)
    );

    assign imem_addr = w_pc;

    // A squash keeps the old PC fields so decode still sees where the killed slot came from.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_instr    <= DATA_W'(NOP_INSTR);
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_misalign <= 1'b0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_valid    <= 1'b0;
            r_instr    <= DATA_W'(NOP_INSTR);
            r_misalign <= |redirect_target[1:0];
        end else if (stall) begin
            r_misalign <= 1'b0;
        end else begin
            r_valid    <= 1'b1;
            r_instr    <= imem_rdata;
            r_pc       <= w_pc;
            r_pc_plus4 <= w_pc + ADDR_W'(WORD_BYTES);
            r_misalign <= 1'b0;
            r_count    <= r_count + 32'd1;
        end
    end

    assign if_id_valid    = r_valid;
    assign if_id_instr    = r_instr;
    assign if_id_pc       = r_pc;
    assign if_id_pc_plus4 = r_pc_plus4;
    assign misalign_err   = r_misalign;
    assign fetch_count    = r_count;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the MIPS32 core; the initiator side of the instruction-memory read interface.
- Owns the program counter and drives the byte address into the combinational instruction memory.
- Registers the returned word, with its PC, into the IF/ID pipeline register.
- Handles stall from the hazard unit and redirect from branch/jump resolution, and counts delivered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- imem_addr  output  ADDR_W  byte address to instruction memory; equals the current PC.
- imem_rdata  input  DATA_W  instruction word from memory; valid combinationally in the same cycle.
- stall  input  1  hold PC and the IF/ID register.
- redirect_valid  input  1  branch/jump taken; load a new PC.
- redirect_target  input  ADDR_W  new PC byte address.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_instr  output  DATA_W  latched instruction.
- if_id_pc  output  ADDR_W  PC of the latched instruction.
- if_id_pc_plus4  output  ADDR_W  if_id_pc + 4.
- misalign_err  output  1  one-cycle pulse: the redirect target had bits [1:0] != 0.
- fetch_count  output  32  number of valid instructions delivered.

Behaviour:
- imem_addr is driven combinationally from the pc register; no other logic sits on that path.
- Reset (rst=1 at posedge):
  - pc <= RESET_PC.
  - if_id_valid <= 0; if_id_instr <= NOP (32'h0000_0000); if_id_pc <= 0; if_id_pc_plus4 <= 0.
  - misalign_err <= 0; fetch_count <= 0.
  - Reset overrides all other inputs, including mid-stall or mid-redirect.
- Per-posedge priority: rst > redirect_valid > stall > normal.
- Normal (no redirect, no stall):
  - if_id_instr <= imem_rdata; if_id_pc <= pc; if_id_pc_plus4 <= pc+4; if_id_valid <= 1.
  - pc <= pc+4.
  - First valid instruction appears one cycle after reset is released (latency 1).
- Stall (stall=1, redirect_valid=0):
  - pc and all IF/ID outputs hold; fetch_count holds; misalign_err <= 0.
- Redirect (redirect_valid=1, regardless of stall):
  - pc <= {redirect_target[ADDR_W-1:2], 2'b00}.
  - IF/ID squashed: if_id_valid <= 0, if_id_instr <= NOP. if_id_pc and if_id_pc_plus4 hold.
  - misalign_err <= |redirect_target[1:0].
- fetch_count increments by 1 on each posedge where if_id_valid is loaded with 1; it wraps at 2^32.
- PC arithmetic is modulo 2^ADDR_W: pc 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Back-to-back redirects: each cycle squashes again. pc follows the last target.
- Stall released the cycle after a redirect: normal fetch resumes from the new pc.
- misalign_err is registered and asserted only in the cycle following a misaligned redirect.

Decomposition:
- Shared package mips32_pkg holds:
  - NOP_INSTR = 32'h0000_0000.
  - WORD_BYTES = 4.
  - Default RESET_PC.
  - Address/data width constants.
  - An if_id_t struct-equivalent field list shared with the decode stage.
- One natural sub-module: pc_reg, holding the PC register with its next-PC mux (reset/redirect/stall/increment).
- The IF/ID register and fetch_count live in the top module.

Test Plan:
- Reset then free-run with the memory preloaded as word i = 32'h1000_0000+i:
  - cycle 1 after reset gives if_id_pc=0, instr=32'h1000_0000, valid=1.
  - cycle 3 gives if_id_pc=8, instr=32'h1000_0002.
  - fetch_count=3.
- stall=1 for 2 cycles when pc=0x10:
  - imem_addr stays 0x10; if_id_pc stays 0x0C; fetch_count is unchanged.
  - After release, the next if_id_pc is 0x10.
- Redirect, aligned target:
  - redirect_valid=1, target=0x40 while pc=0x14 → next cycle if_id_valid=0, instr=0, imem_addr=0x40.
  - The following cycle gives if_id_pc=0x40, valid=1.
- Redirect and stall together (redirect_valid=1, stall=1), target=0x80 → pc=0x80, squash occurs.
- Redirect, misaligned target: target=0x43 → pc=0x40, misalign_err=1 for exactly one cycle.
- Wrap: RESET_PC=32'hFFFF_FFFC → first if_id_pc=0xFFFF_FFFC, pc_plus4=0, next if_id_pc=0.
- Mid-redirect reset: rst=1 with redirect_valid=1, target=0x200 → pc=RESET_PC, valid=0, fetch_count=0.
